// File: rtl/signal_debouncer_pkg.sv
// Shared definitions for the signal debouncer: counter sizing, parameter
// legality and the edge-event encoding used by each debounce cell.
package signal_debouncer_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (longint unsigned w = 1; w < longint'(value); w = w << 1) begin
            result++;
        end
        return result;
    endfunction

    // A single-cycle debounce still needs one bit of counter storage.
    function automatic int unsigned counter_width(input int unsigned debounce_cycles);
        int unsigned w;
        w = clog2(debounce_cycles);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit params_legal(input int unsigned number_of_signals,
                                        input int unsigned debounce_cycles);
        return (number_of_signals >= 1) && (debounce_cycles >= 1);
    endfunction

endpackage

// File: rtl/signal_debouncer_debounce_cell.sv
// Single-bit debounce: run-length counter, debounced level, one-cycle
// rise/fall pulses and a sticky change flag with set-over-clear priority.
module debounce_cell
    import signal_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        RST_LEVEL       = 1'b0
) (
    input  logic clk,
    input  logic srst_n,
    input  logic ena,
    input  logic sig,
    input  logic clr,
    output logic level,
    output logic rise,
    output logic fall,
    output logic changed,
    output logic changed_next
);

    localparam int unsigned    CW   = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          level_next;
    edge_e         ev;

    always_comb begin
        count_next = count;
        level_next = level;
        ev         = EDGE_NONE;
        if (ena) begin
            if (sig == level) begin
                count_next = '0;
            end else if (count == LAST) begin
                count_next = '0;
                level_next = sig;
                ev         = sig ? EDGE_RISE : EDGE_FALL;
            end else begin
                count_next = count + 1'b1;
            end
        end
    end

    // A flip on the same edge as a clear wins, so no event is lost.
    always_comb begin
        changed_next = changed;
        if (ev != EDGE_NONE) begin
            changed_next = 1'b1;
        end else if (clr) begin
            changed_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            count   <= '0;
            level   <= RST_LEVEL;
            rise    <= 1'b0;
            fall    <= 1'b0;
            changed <= 1'b0;
        end else begin
            count   <= count_next;
            level   <= level_next;
            rise    <= (ev == EDGE_RISE);
            fall    <= (ev == EDGE_FALL);
            changed <= changed_next;
        end
    end

endmodule

// File: rtl/signal_debouncer.sv
// Per-signal debounce and edge-event stage downstream of the glitch filter;
// one debounce cell per bit plus a registered any-change summary.
module signal_debouncer
    import signal_debouncer_pkg::*;
#(
    parameter int unsigned                  NUMBER_OF_SIGNALS = 1,
    parameter logic [NUMBER_OF_SIGNALS-1:0] RST_VALUE         = '0,
    parameter int unsigned                  DEBOUNCE_CYCLES   = 4
) (
    input  logic                         iClk,
    input  logic                         iSRst_n,
    input  logic                         iEna,
    input  logic [NUMBER_OF_SIGNALS-1:0] iSignal,
    input  logic [NUMBER_OF_SIGNALS-1:0] iClr,
    output logic [NUMBER_OF_SIGNALS-1:0] oLevel,
    output logic [NUMBER_OF_SIGNALS-1:0] oRise,
    output logic [NUMBER_OF_SIGNALS-1:0] oFall,
    output logic [NUMBER_OF_SIGNALS-1:0] oChanged,
    output logic                         oAnyChange
);

    if (!params_legal(NUMBER_OF_SIGNALS, DEBOUNCE_CYCLES)) begin : g_param_error
        $error("signal_debouncer: NUMBER_OF_SIGNALS and DEBOUNCE_CYCLES must both be >= 1");
    end

    logic [NUMBER_OF_SIGNALS-1:0] changed_next;

    for (genvar i = 0; i < NUMBER_OF_SIGNALS; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_LEVEL       (RST_VALUE[i])
        ) u_cell (
            .clk          (iClk),
            .srst_n       (iSRst_n),
            .ena          (iEna),
            .sig          (iSignal[i]),
            .clr          (iClr[i]),
            .level        (oLevel[i]),
            .rise         (oRise[i]),
            .fall         (oFall[i]),
            .changed      (oChanged[i]),
            .changed_next (changed_next[i])
        );
    end

    // Built from next-state flags so it moves on the same edge as oChanged.
    always_ff @(posedge iClk) begin
        if (!iSRst_n) begin
            oAnyChange <= 1'b0;
        end else begin
            oAnyChange <= |changed_next;
        end
    end

endmodule

// File: tb/tb_signal_debouncer.sv
// Directed and randomized checks of two debouncer configurations against a
// sample-history reference model.
module tb_signal_debouncer;

    logic iClk = 1'b0;
    always #5 iClk = ~iClk;

    logic       iSRst_n;
    logic       iEna;
    logic [3:0] sig_a, clr_a, lvl_a, rise_a, fall_a, chg_a;
    logic       any_a;
    logic [1:0] sig_b, clr_b, lvl_b, rise_b, fall_b, chg_b;
    logic       any_b;

    signal_debouncer #(
        .NUMBER_OF_SIGNALS (4),
        .RST_VALUE         (4'b0010),
        .DEBOUNCE_CYCLES   (4)
    ) dut_a (
        .iClk       (iClk),
        .iSRst_n    (iSRst_n),
        .iEna       (iEna),
        .iSignal    (sig_a),
        .iClr       (clr_a),
        .oLevel     (lvl_a),
        .oRise      (rise_a),
        .oFall      (fall_a),
        .oChanged   (chg_a),
        .oAnyChange (any_a)
    );

    signal_debouncer #(
        .NUMBER_OF_SIGNALS (2),
        .RST_VALUE         (2'b01),
        .DEBOUNCE_CYCLES   (1)
    ) dut_b (
        .iClk       (iClk),
        .iSRst_n    (iSRst_n),
        .iEna       (iEna),
        .iSignal    (sig_b),
        .iClr       (clr_b),
        .oLevel     (lvl_b),
        .oRise      (rise_b),
        .oFall      (fall_b),
        .oChanged   (chg_b),
        .oAnyChange (any_b)
    );

    int checks = 0;
    int errors = 0;
    bit toggle_b = 1'b1;

    // Reference model: a bit flips once its last DC enabled samples since the
    // previous flip/reset all disagree with the current level.
    int unsigned m_dc  [2] = '{4, 1};
    int unsigned m_n   [2] = '{4, 2};
    logic [3:0]  m_rst [2] = '{4'b0010, 4'b0001};
    logic [3:0]  m_lvl [2];
    logic [3:0]  m_rise[2];
    logic [3:0]  m_fall[2];
    logic [3:0]  m_chg [2];
    logic        m_any [2];
    bit          hist  [2][4][$];

    task automatic model_step(input int d, input logic [3:0] sig, input logic [3:0] clr);
        bit flip;
        if (!iSRst_n) begin
            m_lvl[d]  = m_rst[d];
            m_rise[d] = '0;
            m_fall[d] = '0;
            m_chg[d]  = '0;
            for (int i = 0; i < 4; i++) hist[d][i].delete();
        end else begin
            m_rise[d] = '0;
            m_fall[d] = '0;
            for (int i = 0; i < int'(m_n[d]); i++) begin
                flip = 1'b0;
                if (iEna) begin
                    hist[d][i].push_back(sig[i]);
                    if (hist[d][i].size() > int'(m_dc[d])) void'(hist[d][i].pop_front());
                    if (hist[d][i].size() == int'(m_dc[d])) begin
                        flip = 1'b1;
                        for (int k = 0; k < hist[d][i].size(); k++)
                            if (hist[d][i][k] == m_lvl[d][i]) flip = 1'b0;
                    end
                end
                if (flip) begin
                    if (m_lvl[d][i]) m_fall[d][i] = 1'b1;
                    else             m_rise[d][i] = 1'b1;
                    m_lvl[d][i] = ~m_lvl[d][i];
                    m_chg[d][i] = 1'b1;
                    hist[d][i].delete();
                end else if (clr[i]) begin
                    m_chg[d][i] = 1'b0;
                end
            end
        end
        m_any[d] = |m_chg[d];
    endtask

    task automatic chk(input string name, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", name, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        model_step(0, sig_a, clr_a);
        model_step(1, {2'b00, sig_b}, {2'b00, clr_b});
        @(posedge iClk);
        #1;
        chk({tag, ".a.level"},   lvl_a,            m_lvl[0]);
        chk({tag, ".a.rise"},    rise_a,           m_rise[0]);
        chk({tag, ".a.fall"},    fall_a,           m_fall[0]);
        chk({tag, ".a.changed"}, chg_a,            m_chg[0]);
        chk({tag, ".a.any"},     {3'b000, any_a},  {3'b000, m_any[0]});
        chk({tag, ".b.level"},   {2'b00, lvl_b},   m_lvl[1]);
        chk({tag, ".b.rise"},    {2'b00, rise_b},  m_rise[1]);
        chk({tag, ".b.fall"},    {2'b00, fall_b},  m_fall[1]);
        chk({tag, ".b.changed"}, {2'b00, chg_b},   m_chg[1]);
        chk({tag, ".b.any"},     {3'b000, any_b},  {3'b000, m_any[1]});
        if (toggle_b) sig_b = ~sig_b;
    endtask

    logic [7:0] bounce;
    logic [6:0] ena_pat;

    initial begin
        iSRst_n = 1'b0;
        iEna    = 1'b1;
        sig_a   = '0;
        clr_a   = '0;
        sig_b   = '0;
        clr_b   = '0;

        // Reset held three cycles with enable high and input differing
        repeat (3) step("reset");
        chk("reset_level", lvl_a, 4'b0010);
        chk("reset_pulses", rise_a | fall_a, 4'b0000);
        chk("reset_flags", {chg_a[3:1], any_a}, 4'b0000);

        // Post-reset: bit 1 falls on the 4th enabled edge
        iSRst_n = 1'b1;
        repeat (3) step("post_reset");
        chk("post_reset_hold", lvl_a, 4'b0010);
        step("post_reset_flip");
        chk("post_reset_fall_level", lvl_a, 4'b0000);
        chk("post_reset_fall_pulse", fall_a, 4'b0010);
        step("post_reset_after");
        chk("post_reset_pulse_one_cycle", fall_a, 4'b0000);
        clr_a = '1;
        step("clear_all");
        clr_a = '0;

        // Bounce rejection on bit 0
        bounce = 8'b1111_0111;
        for (int j = 0; j < 8; j++) begin
            sig_a[0] = bounce[j];
            step("bounce");
            if (j == 6) chk("bounce_hold_7th", lvl_a, 4'b0000);
            if (j == 7) chk("bounce_rise_8th", rise_a, 4'b0001);
        end
        step("bounce_after");
        chk("bounce_single_pulse", rise_a, 4'b0000);

        // Enable gating on bit 3
        sig_a   = 4'b1001;
        ena_pat = 7'b1011001;
        for (int j = 0; j < 7; j++) begin
            iEna = ena_pat[j];
            step("ena_gate");
            if (j == 5) chk("ena_gate_hold_6th", lvl_a, 4'b0001);
            if (j == 6) chk("ena_gate_flip_7th", lvl_a, 4'b1001);
        end
        iEna  = 1'b1;
        clr_a = '1;
        step("clear_all2");
        clr_a = '0;

        // Sticky collision: clear asserted on the flip edge of bit 0
        sig_a = 4'b1000;
        repeat (3) step("sticky_count");
        clr_a = 4'b0001;
        step("sticky_collide");
        chk("sticky_set_wins", chg_a, 4'b0001);
        clr_a = '1;
        step("sticky_clear");
        chk("sticky_cleared", chg_a, 4'b0000);
        chk("sticky_any_cleared", {3'b000, any_a}, 4'b0000);
        clr_a = '0;

        // Bits 0 and 2 rise together while bit 1 bounces
        sig_a = 4'b1111; step("multi");
        sig_a = 4'b1101; step("multi");
        sig_a = 4'b1111; step("multi");
        sig_a = 4'b1101; step("multi");
        chk("multi_rise", rise_a, 4'b0101);
        chk("multi_level", lvl_a, 4'b1101);
        step("multi_after");
        chk("multi_single_pulse", rise_a, 4'b0000);

        // Reset mid-count discards three differing samples
        sig_a = 4'b0010;
        repeat (3) step("midcount");
        iSRst_n = 1'b0;
        step("midcount_reset");
        iSRst_n = 1'b1;
        sig_a   = 4'b1101;
        repeat (3) step("midcount_post");
        chk("midcount_hold", lvl_a, 4'b0010);
        step("midcount_flip");
        chk("midcount_flip_level", lvl_a, 4'b1101);

        // Randomized phase
        toggle_b = 1'b0;
        for (int j = 0; j < 600; j++) begin
            iSRst_n = ($urandom_range(0, 59) != 0);
            iEna    = ($urandom_range(0, 4) != 0);
            sig_a   = sig_a ^ 4'($urandom & $urandom & $urandom);
            sig_b   = 2'($urandom);
            clr_a   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            clr_b   = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/signal_debouncer.md
# signal_debouncer

Per-signal debounce and edge-event stage consuming the glitch-filtered signal vector. Each bit must hold a new level for DEBOUNCE_CYCLES consecutive enabled samples before its debounced level changes. On each change the block emits a one-cycle rise or fall pulse and sets a sticky change flag, which software or control logic clears by mask. It sits directly downstream of the glitch filter, and its iSignal is that filter's filtered output.

## Interface
- NUMBER_OF_SIGNALS, 1: width of the signal vector; must be ≥1.
- RST_VALUE, 0: reset value of oLevel, NUMBER_OF_SIGNALS bits.
- DEBOUNCE_CYCLES, 4: consecutive differing enabled samples required to change level; must be ≥1.

Ports:
- iClk  in  1  clock; all logic on rising edge.
- iSRst_n  in  1  synchronous reset, active-low. One clock and this one reset only; there is no asynchronous reset.
- iEna  in  1  sample enable, active-high.
- iSignal  in  NUMBER_OF_SIGNALS  glitch-filtered input vector.
- iClr  in  NUMBER_OF_SIGNALS  per-bit sticky-flag clear, level-sensitive.
- oLevel  out  NUMBER_OF_SIGNALS  debounced level.
- oRise  out  NUMBER_OF_SIGNALS  one-cycle pulse when oLevel[i] goes 0→1.
- oFall  out  NUMBER_OF_SIGNALS  one-cycle pulse when oLevel[i] goes 1→0.
- oChanged  out  NUMBER_OF_SIGNALS  sticky flag: oLevel[i] changed since last clear.
- oAnyChange  out  1  OR-reduction of oChanged, registered.

## Operation
- Reset (iSRst_n=0 at an edge): oLevel=RST_VALUE, all counters 0, oRise=oFall=0, oChanged=0, oAnyChange=0. Reset overrides iEna and iClr.
- Each bit i has one counter, CW = max(1, clog2(DEBOUNCE_CYCLES)) bits wide.
- Per bit i, at an edge with iEna=1:
  - If iSignal[i]==oLevel[i], the counter clears to 0.
  - Else if count == DEBOUNCE_CYCLES-1: oLevel[i] flips, the counter clears to 0, and oRise[i] or oFall[i] asserts for the next cycle only.
  - Else the counter increments.
- Any agreeing sample resets the count. Differing samples need not be consecutive in clock cycles, only consecutive among enabled samples.
- iEna=0: counters and oLevel hold; oRise/oFall deassert.
- oChanged[i]:
  - Set when oLevel[i] flips.
  - Else cleared when iClr[i]=1.
  - Else holds.
  - A set and a clear on the same edge leave the flag at 1, so no event is lost.
- iClr is honoured regardless of iEna.
- oAnyChange is the registered OR of the next-state oChanged, so it updates on the same edge as oChanged.
- Counters never exceed DEBOUNCE_CYCLES-1, so no wrap-around occurs.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: if iSignal[i] differs from oLevel[i] on N=DEBOUNCE_CYCLES consecutive enabled edges e1..eN, then oLevel[i] and the pulse become visible after eN.
- DEBOUNCE_CYCLES=1: oLevel follows iSignal one cycle late whenever enabled.
- Pulses last exactly one cycle. Consecutive flips, possible only when DEBOUNCE_CYCLES=1, produce back-to-back pulses.
- Reset mid-count discards the partial count. The first post-reset edge is treated as a normal sample against RST_VALUE.
- Bits are fully independent. Simultaneous flips on several bits each pulse in the same cycle.

## Structure
- Shared package holds:
  - the clog2 function,
  - the derived counter-width localparam rule,
  - parameter legality checks (NUMBER_OF_SIGNALS≥1, DEBOUNCE_CYCLES≥1), which raise an elaboration error when violated.
- One sub-module, debounce_cell: single-bit counter, level, rise/fall and sticky flag.
- The top level instantiates NUMBER_OF_SIGNALS cells in a generate loop and registers oAnyChange.

## Test plan
- Reset: RST_VALUE=1, hold iSRst_n=0 for 3 cycles with iSignal=0 and iEna=1 → oLevel=1, all pulses and flags 0. After release, oLevel stays 1 for exactly 3 enabled edges, then falls with oFall=1 for one cycle.
- Bounce rejection: DEBOUNCE_CYCLES=4, oLevel=0; drive iSignal 1,1,1,0,1,1,1,1 → oLevel rises only after the 8th edge; exactly one oRise pulse.
- Enable gating: input held differing; iEna pattern 1,0,0,1,1,0,1 → flip after the 7th edge, i.e. the 4th enabled sample. oLevel and counters hold while iEna=0.
- Sticky collision: iClr[0]=1 held across the edge where bit 0 flips → oChanged[0]=1 afterwards. iClr[0]=1 one cycle later → oChanged[0]=0 and oAnyChange=0.
- Multi-bit independence: NUMBER_OF_SIGNALS=4; bits 0 and 2 rise simultaneously while bit 1 bounces → oRise=4'b0101 for one cycle, bit 1 unchanged. DEBOUNCE_CYCLES=1 with toggling iSignal gives alternating single-cycle rise/fall pulses.
- Reset mid-count: 3 of 4 differing samples, then iSRst_n=0 for one cycle → count discarded. 4 further differing samples are needed before the flip.
